// File: rtl/ram_1r1w_queue_ctrl.sv
// Pointer/flag controller for a circular queue held in an external 1R1W
// async-read RAM; the head entry is read combinationally from the RAM.
module ram_1r1w_queue_ctrl #(
  parameter int DEPTH        = 64,
  parameter int INDEX        = 6,
  parameter int WIDTH        = 32,
  parameter int AFULL_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             almost_full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic [INDEX:0]   count_o,
  output logic [INDEX-1:0] ram_addr0_o,
  output logic [INDEX-1:0] ram_addr0wr_o,
  output logic             ram_we0_o,
  output logic [WIDTH-1:0] ram_data0wr_o,
  input  logic [WIDTH-1:0] ram_data0_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [INDEX:0]   DEPTH_C = (INDEX+1)'(DEPTH);
  localparam logic [INDEX-1:0] LAST    = INDEX'(DEPTH-1);

  logic [INDEX-1:0] head, tail;
  logic [INDEX:0]   count, free;
  logic             pop_acc, push_acc;

  // Reset gates acceptance so the RAM write enable drops the moment reset asserts.
  always_comb begin
    empty_o       = (count == '0);
    full_o        = (count == DEPTH_C);
    free          = DEPTH_C - count;
    almost_full_o = (32'(free) <= 32'(AFULL_THRESH));
    pop_acc       = pop_i & ~empty_o & ~flush_i & ~reset;
    push_acc      = push_i & ~flush_i & ~reset & (~full_o | pop_acc);
    ram_we0_o     = push_acc;
    ram_addr0wr_o = tail;
    ram_data0wr_o = push_data_i;
    ram_addr0_o   = head;
    pop_data_o    = ram_data0_i;
    count_o       = count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_acc) tail <= (tail == LAST) ? '0 : tail + 1'b1;
      if (pop_acc)  head <= (head == LAST) ? '0 : head + 1'b1;
      count <= count + (INDEX+1)'(push_acc) - (INDEX+1)'(pop_acc);
      if (push_i & ~push_acc) overflow_o  <= 1'b1;
      if (pop_i & empty_o)    underflow_o <= 1'b1;
    end
  end

endmodule
